// File: rtl/conv_pkg.sv
// Shared width helpers, saturation and packing conventions for the
// parametrised convolution calculator and its adder trees.
package conv_pkg;

   function automatic int prod_w(input int data_w, input int w_w);
      return data_w + w_w;
   endfunction

   function automatic int levels(input int n);
      return (n > 1) ? $clog2(n) : 0;
   endfunction

   function automatic int acc_w(input int data_w, input int w_w, input int taps);
      return prod_w(data_w, w_w) + levels(taps);
   endfunction

   // Index port width, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Window tap t and channel c both live at [idx*w +: w] in their flat vectors.
   function automatic int slot_lsb(input int idx, input int w);
      return idx * w;
   endfunction

   function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Pipelined pairwise signed adder tree: one register level per halving,
// sum valid $clog2(N_IN) enabled cycles after the inputs.
module adder_tree_pipe
   import conv_pkg::*;
#(
   parameter int N_IN = 25,
   parameter int IN_W = 16,
   localparam int LEVELS = levels(N_IN),
   localparam int SUM_W = IN_W + LEVELS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [N_IN*IN_W-1:0]   in_vec,
   output logic [SUM_W-1:0]       sum
);

   generate
      if (LEVELS == 0) begin : g_pass
         assign sum = SUM_W'($signed(in_vec));
      end else begin : g_tree
         logic [LEVELS:1][N_IN-1:0][SUM_W-1:0]   lvl_q;
         logic [LEVELS:1][N_IN-1:0][SUM_W-1:0]   lvl_d;
         logic [LEVELS-1:0][N_IN-1:0][SUM_W-1:0] src;
         logic                                   unused_hi;

         // Entries beyond a level's live count stay zero, so an odd element
         // passes through simply by being added to a zero neighbour.
         always_comb begin
            src = '0;
            for (int i = 0; i < N_IN; i++)
               src[0][i] = SUM_W'($signed(in_vec[slot_lsb(i, IN_W) +: IN_W]));
            for (int l = 1; l < LEVELS; l++)
               src[l] = lvl_q[l];
         end

         always_comb begin
            lvl_d = '0;
            for (int l = 1; l <= LEVELS; l++) begin
               for (int i = 0; i < N_IN; i++) begin
                  lvl_d[l][i] = ((2*i < N_IN) ? src[l-1][(2*i < N_IN) ? 2*i : 0] : '0)
                              + ((2*i+1 < N_IN) ? src[l-1][(2*i+1 < N_IN) ? 2*i+1 : 0] : '0);
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lvl_q <= '0;
            else if (en) lvl_q <= lvl_d;
         end

         assign sum       = lvl_q[LEVELS][0];
         assign unused_hi = ^lvl_q[LEVELS][N_IN-1:1];
      end
   endgenerate

endmodule

// File: rtl/conv_calc_param.sv
// KxK window convolution over N_CH channels with runtime-loadable weights
// and biases, floor shift, optional ReLU, saturation and output backpressure.
module conv_calc_param
   import conv_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int W_W     = 8,
   parameter int K       = 5,
   parameter int N_CH    = 3,
   parameter int OUT_W   = 12,
   parameter int SHIFT   = 7,
   parameter int RELU_EN = 0,
   localparam int TAPS   = K * K,
   localparam int CH_W   = idx_w(N_CH),
   localparam int TAP_W  = idx_w(TAPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   output logic                     in_ready,
   input  logic [TAPS*DATA_W-1:0]   data_in,
   input  logic                     wr_en,
   input  logic                     wr_is_bias,
   input  logic [CH_W-1:0]          wr_ch,
   input  logic [TAP_W-1:0]         wr_tap,
   input  logic [W_W-1:0]           wr_data,
   output logic                     valid_out,
   input  logic                     out_ready,
   output logic [N_CH*OUT_W-1:0]    conv_out,
   output logic                     idle
);

   localparam int PROD_W = prod_w(DATA_W, W_W);
   localparam int LEVELS = levels(TAPS);
   localparam int ACC_W  = acc_w(DATA_W, W_W, TAPS);
   localparam int NV     = LEVELS + 2;

   logic                             en;
   logic signed [W_W-1:0]            weight [N_CH][TAPS];
   logic signed [W_W-1:0]            bias   [N_CH];
   logic [TAPS*DATA_W-1:0]           win_q;
   logic [NV-1:0]                    v_q;
   logic [N_CH-1:0][TAPS*PROD_W-1:0] prod_d;
   logic [N_CH-1:0][TAPS*PROD_W-1:0] prod_q;
   logic [N_CH-1:0][ACC_W-1:0]       acc;
   logic [N_CH*OUT_W-1:0]            out_d;

   // Handshakes: a beat transfers on valid_in && in_ready, a result on
   // valid_out && out_ready. A held result freezes the whole pipeline.
   assign en       = !(valid_out && !out_ready);
   assign in_ready = en;
   assign idle     = !(|v_q) && !valid_out;

   // Coefficient writes ignore en so they can land while the output stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            bias[c] <= '0;
            for (int t = 0; t < TAPS; t++) weight[c][t] <= '0;
         end
      end else if (wr_en && (32'(wr_ch) < N_CH)) begin
         if (wr_is_bias) bias[wr_ch] <= wr_data;
         else if (32'(wr_tap) < TAPS) weight[wr_ch][wr_tap] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= '0;
         v_q   <= '0;
      end else if (en) begin
         win_q <= data_in;
         v_q   <= {v_q[NV-2:0], valid_in};
      end
   end

   always_comb begin
      prod_d = '0;
      for (int c = 0; c < N_CH; c++) begin
         for (int t = 0; t < TAPS; t++) begin
            prod_d[c][slot_lsb(t, PROD_W) +: PROD_W] =
               PROD_W'($signed(win_q[slot_lsb(t, DATA_W) +: DATA_W])) * PROD_W'(weight[c][t]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prod_q <= '0;
      else if (en) prod_q <= prod_d;
   end

   generate
      for (genvar c = 0; c < N_CH; c++) begin : g_ch
         adder_tree_pipe #(
            .N_IN (TAPS),
            .IN_W (PROD_W)
         ) u_tree (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .in_vec (prod_q[c]),
            .sum    (acc[c])
         );
      end
   endgenerate

   // Bias is sampled here, in the cycle the beat enters the output register.
   always_comb begin
      logic signed [63:0] r;
      r     = '0;
      out_d = '0;
      for (int c = 0; c < N_CH; c++) begin
         r = (64'($signed(acc[c])) + 64'(bias[c])) >>> SHIFT;
         if ((RELU_EN != 0) && (r < 0)) r = '0;
         out_d[slot_lsb(c, OUT_W) +: OUT_W] = OUT_W'(sat_s(r, OUT_W));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         conv_out  <= '0;
      end else if (en) begin
         valid_out <= v_q[NV-1];
         if (v_q[NV-1]) conv_out <= out_d;
      end
   end

endmodule

// File: tb/tb_conv_calc_param.sv
// Directed bench for conv_calc_param: plain and ReLU instances share stimulus,
// results are checked against hand-computed values and a small reference model.
module tb_conv_calc_param;

   localparam int DATA_W = 8;
   localparam int W_W    = 8;
   localparam int K      = 5;
   localparam int TAPS   = K * K;
   localparam int N_CH   = 3;
   localparam int OUT_W  = 12;
   localparam int SHIFT  = 7;
   localparam int OV_W   = N_CH * OUT_W;
   localparam int WIN_W  = TAPS * DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              valid_in = 1'b0;
   logic [WIN_W-1:0]  data_in = '0;
   logic              wr_en = 1'b0;
   logic              wr_is_bias = 1'b0;
   logic [1:0]        wr_ch = '0;
   logic [4:0]        wr_tap = '0;
   logic [W_W-1:0]    wr_data = '0;
   logic              out_ready = 1'b1;
   logic              in_ready, valid_out, idle;
   logic [OV_W-1:0]   conv_out;
   logic              in_ready_r, valid_out_r, idle_r;
   logic [OV_W-1:0]   conv_out_r;

   int                n_checks = 0;
   int                n_fail = 0;
   logic [OV_W-1:0]   exp_q[$];
   logic [OV_W-1:0]   exp_r_q[$];
   int                w_sh [N_CH][TAPS];
   int                b_sh [N_CH];

   conv_calc_param #(
      .DATA_W(DATA_W), .W_W(W_W), .K(K), .N_CH(N_CH),
      .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU_EN(0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
      .data_in(data_in), .wr_en(wr_en), .wr_is_bias(wr_is_bias), .wr_ch(wr_ch),
      .wr_tap(wr_tap), .wr_data(wr_data), .valid_out(valid_out),
      .out_ready(out_ready), .conv_out(conv_out), .idle(idle)
   );

   conv_calc_param #(
      .DATA_W(DATA_W), .W_W(W_W), .K(K), .N_CH(N_CH),
      .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU_EN(1)
   ) u_relu (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready_r),
      .data_in(data_in), .wr_en(wr_en), .wr_is_bias(wr_is_bias), .wr_ch(wr_ch),
      .wr_tap(wr_tap), .wr_data(wr_data), .valid_out(valid_out_r),
      .out_ready(out_ready), .conv_out(conv_out_r), .idle(idle_r)
   );

   // Clock and watchdog
   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [OV_W-1:0] pack3(input int c0, input int c1, input int c2);
      return {OUT_W'(c2), OUT_W'(c1), OUT_W'(c0)};
   endfunction

   function automatic logic [WIN_W-1:0] fill(input int v);
      logic [WIN_W-1:0] w;
      for (int t = 0; t < TAPS; t++) w[t*DATA_W +: DATA_W] = DATA_W'(v);
      return w;
   endfunction

   function automatic logic [WIN_W-1:0] ramp(input int k);
      logic [WIN_W-1:0] w;
      for (int t = 0; t < TAPS; t++) w[t*DATA_W +: DATA_W] = DATA_W'(k + t - 12);
      return w;
   endfunction

   function automatic logic [OV_W-1:0] model(input logic [WIN_W-1:0] win, input bit relu);
      logic [OV_W-1:0] o;
      longint acc, r, hi, lo;
      o  = '0;
      hi = (64'sd1 <<< (OUT_W - 1)) - 1;
      lo = -hi - 1;
      for (int c = 0; c < N_CH; c++) begin
         acc = b_sh[c];
         for (int t = 0; t < TAPS; t++)
            acc += longint'($signed(win[t*DATA_W +: DATA_W])) * w_sh[c][t];
         r = acc >>> SHIFT;
         if (relu && r < 0) r = 0;
         if (r > hi) r = hi;
         if (r < lo) r = lo;
         o[c*OUT_W +: OUT_W] = OUT_W'(r);
      end
      return o;
   endfunction

   // Driver tasks (entered just after a rising edge)
   task automatic write_coef(input bit is_bias, input int ch, input int tap, input int val);
      wr_en = 1'b1; wr_is_bias = is_bias; wr_ch = 2'(ch); wr_tap = 5'(tap); wr_data = W_W'(val);
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (ch < N_CH) begin
         if (is_bias) b_sh[ch] = val;
         else if (tap < TAPS) w_sh[ch][tap] = val;
      end
   endtask

   task automatic send_beat(input logic [WIN_W-1:0] win, input logic [OV_W-1:0] e,
                            input logic [OV_W-1:0] er);
      int guard;
      guard = 0;
      valid_in = 1'b1;
      data_in  = win;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check_eq("accept_timeout", 64'(guard), 64'd0);
      @(posedge clk); #1;
      exp_q.push_back(e);
      exp_r_q.push_back(er);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && (exp_q.size() != 0 || exp_r_q.size() != 0); i++)
         @(negedge clk);
      check_eq("drain", 64'(exp_q.size() + exp_r_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic clear_shadow();
      for (int c = 0; c < N_CH; c++) begin
         b_sh[c] = 0;
         for (int t = 0; t < TAPS; t++) w_sh[c][t] = 0;
      end
   endtask

   // Scoreboard: every output handshake pops one expected result
   always @(negedge clk) begin
      if (valid_out && out_ready) begin
         if (exp_q.size() == 0) check_eq("spurious_out", 64'(valid_out), 64'd0);
         else check_eq("out", 64'(conv_out), 64'(exp_q.pop_front()));
      end
      if (valid_out_r && out_ready) begin
         if (exp_r_q.size() == 0) check_eq("spurious_relu", 64'(valid_out_r), 64'd0);
         else check_eq("relu_out", 64'(conv_out_r), 64'(exp_r_q.pop_front()));
      end
   end

   initial begin
      logic [WIN_W-1:0] win;
      int lat;
      int g;
      clear_shadow();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check_eq("rst_conv_out", 64'(conv_out), 64'd0);
      check_eq("rst_valid_out", 64'(valid_out), 64'd0);
      check_eq("rst_idle", 64'(idle), 64'd1);
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Single product and latency: 100*64 = 6400 >>> 7 = 50
      write_coef(0, 0, 12, 64);
      write_coef(1, 0, 0, 0);
      win = '0;
      win[12*DATA_W +: DATA_W] = 8'd100;
      send_beat(win, pack3(50, 0, 0), pack3(50, 0, 0));
      valid_in = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!valid_out && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", 64'(lat), 64'd8);
      @(negedge clk);
      check_eq("valid_pulse", 64'(valid_out), 64'd0);
      check_eq("idle_after", 64'(idle), 64'd1);
      @(posedge clk); #1;

      // Saturation: +3150 -> 2047, -3175 -> -2048 (ReLU -> 0)
      for (int c = 0; c < N_CH; c++)
         for (int t = 0; t < TAPS; t++) write_coef(0, c, t, 127);
      send_beat(fill(127), pack3(2047, 2047, 2047), pack3(2047, 2047, 2047));
      send_beat(fill(-128), pack3(-2048, -2048, -2048), pack3(0, 0, 0));
      valid_in = 1'b0;
      wait_drain();

      // Floor rounding: ch0 -127-1 = -128 -> -1, ch1/ch2 -127 -> -1
      write_coef(1, 0, 0, -1);
      win = '0;
      win[DATA_W-1:0] = 8'hff;
      send_beat(win, pack3(-1, -1, -1), pack3(0, 0, 0));
      valid_in = 1'b0;
      wait_drain();

      // Backpressure: 10 ramp beats, out_ready low 3 cycles mid-stream
      fork
         begin
            for (int k = 0; k < 10; k++) send_beat(ramp(k), model(ramp(k), 0), model(ramp(k), 1));
            valid_in = 1'b0;
         end
         begin
            g = 0;
            @(negedge clk);
            while (!valid_out && g < 50) begin
               @(negedge clk);
               g++;
            end
            if (g >= 50) check_eq("bp_wait", 64'(g), 64'd0);
            @(posedge clk); #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check_eq("bp_in_ready", 64'(in_ready), 64'd0);
               check_eq("bp_hold", 64'(valid_out), 64'd1);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Out-of-range writes change nothing: 25*127-1 >>> 7 = 24, 3175 >>> 7 = 24
      write_coef(0, 0, 25, 5);
      write_coef(1, 3, 0, 5);
      write_coef(0, 3, 0, 5);
      send_beat(fill(1), pack3(24, 24, 24), pack3(24, 24, 24));
      valid_in = 1'b0;
      wait_drain();

      // Write in the accept cycle: ch1 tap0 -> 0 gives 24*127 >>> 7 = 23
      wr_en = 1'b1; wr_is_bias = 1'b0; wr_ch = 2'd1; wr_tap = 5'd0; wr_data = '0;
      valid_in = 1'b1; data_in = fill(1);
      @(negedge clk);
      check_eq("simul_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      wr_en = 1'b0; valid_in = 1'b0;
      w_sh[1][0] = 0;
      exp_q.push_back(pack3(24, 23, 24));
      exp_r_q.push_back(pack3(24, 23, 24));
      wait_drain();

      // Reset with beats in flight
      for (int k = 0; k < 4; k++) send_beat(fill(2), model(fill(2), 0), model(fill(2), 1));
      valid_in = 1'b0;
      g = 0;
      @(negedge clk);
      while (!valid_out && g < 20) begin
         @(negedge clk);
         g++;
      end
      check_eq("mid_valid_seen", 64'(valid_out), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_valid_out", 64'(valid_out), 64'd0);
      check_eq("arst_conv_out", 64'(conv_out), 64'd0);
      check_eq("arst_idle", 64'(idle), 64'd1);
      exp_q.delete();
      exp_r_q.delete();
      clear_shadow();
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_idle", 64'(idle), 64'd1);
      check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      send_beat(fill(100), pack3(0, 0, 0), pack3(0, 0, 0));
      valid_in = 1'b0;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_calc_param.md
Name: conv_calc_param

Overview:
- Parametrised successor of the fixed 5x5, 3-channel conv1 calculator.
- Takes one KxK window of signed pixels per beat and computes N_CH channel outputs in parallel.
- Weights and biases are runtime-loadable registers, not constant ROMs.
- Adds saturation, optional ReLU and output backpressure. Sits between the line-buffer window generator and the pooling stage.

Parameters:
DATA_W, 8, signed pixel width
W_W, 8, signed weight and bias width
K, 5, kernel side; TAPS = K*K
N_CH, 3, output channels
OUT_W, 12, signed output width
SHIFT, 7, arithmetic right shift applied after the bias add
RELU_EN, 0, 1 = clamp negative results to 0 before saturation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  window beat valid
in_ready  out  1  beat accepted when valid_in && in_ready
data_in  in  TAPS*DATA_W  window, tap t at bits [t*DATA_W +: DATA_W], row-major
wr_en  in  1  coefficient write strobe
wr_is_bias  in  1  1 = write bias[wr_ch]; 0 = write weight[wr_ch][wr_tap]
wr_ch  in  $clog2(N_CH) (min 1)  channel index
wr_tap  in  $clog2(TAPS)  tap index
wr_data  in  W_W  signed coefficient
valid_out  out  1  conv_out valid
out_ready  in  1  downstream accepts
conv_out  out  N_CH*OUT_W  channel c at [c*OUT_W +: OUT_W]
idle  out  1  no valid beat anywhere in the pipeline

Behaviour:
- Reset (async assert, sync release): all weights, biases and pipeline data = 0; all valid bits = 0; valid_out = 0; conv_out = 0; idle = 1; in_ready = 1.
- Global enable: en = !(valid_out && !out_ready). When en = 0, every stage holds, including valid bits. in_ready = en.
- Stages:
  - S0: register the window.
  - S1: TAPS x N_CH signed multiplies, PROD_W = DATA_W+W_W.
  - Adder tree: LEVELS = $clog2(TAPS) stages of pairwise adds. An odd element passes through; width grows 1 bit per level to ACC_W = PROD_W+LEVELS.
  - SO: output stage, described below.
- Latency: LEVELS+3 enabled cycles from accept to valid_out. Default is 8. Throughput is 1 beat/cycle while out_ready = 1.
- Output stage, per channel:
  - r = (acc + sign-extended bias) >>> SHIFT, arithmetic, floor rounding.
  - If RELU_EN and r < 0, r = 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - conv_out updates only when a valid beat enters SO; otherwise it holds its last value.
- Valid bits shift alongside data. Bubbles are allowed: data regs may load garbage, but valid_out stays 0 for bubbles.
- Coefficient writes:
  - Take effect at the edge where wr_en = 1, independent of en.
  - A beat uses the coefficients present during the cycle it occupies S1 (weights) or SO (bias).
  - Writes while idle = 0 are performed, but in-flight results are then unspecified; the controller writes only when idle = 1.
  - Out-of-range wr_ch or wr_tap: write ignored, no state change.
- Simultaneous events:
  - A write and an accept in the same cycle: the accepted beat sees the new weight in S1.
  - valid_out && out_ready with a new accept: pipeline advances, no beat lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded and coefficients are cleared; they must be reloaded.
- idle = no valid bit set in S0..SO and valid_out = 0.

Decomposition:
- Shared package conv_pkg holds: width helpers (PROD_W, ACC_W and LEVELS calculations), a signed saturate function, and the window/channel packing index conventions.
- One sub-module, adder_tree_pipe: parameters N_IN and IN_W; inputs en and a flattened input vector; registered sum out after $clog2(N_IN) cycles.
- The top instantiates N_CH adder trees.

Test Plan:
1. Reset: check all outputs are 0, idle = 1, in_ready = 1. Write ch0 tap12 = 64, bias0 = 0; send tap12 = 100, other taps 0 -> 8 cycles later valid_out for 1 cycle, ch0 = 50 (6400>>>7), ch1 = ch2 = 0.
2. Saturation: all weights = 127, all data = 127 -> 403225>>>7 = 3150 -> 2047. All data = -128 -> -3175 -> -2048.
3. Floor rounding and bias: single product -128 (data -1, weight 127, bias -1) -> -128>>>7 = -1. Same with RELU_EN = 1 -> 0.
4. Backpressure: 10 back-to-back beats with ramping data; hold out_ready = 0 for 3 cycles mid-stream -> in_ready low those cycles, all 10 results arrive in order, matching the model, none duplicated.
5. Boundary writes: wr_tap = 25 and wr_ch = 3 (default params) -> no coefficient changes. A write in the same cycle as an accept -> that beat uses the new weight.
6. Reset asserted mid-stream with 4 beats in flight -> valid_out = 0 immediately (async); after release, idle = 1 and an input produces 0 outputs until coefficients are reloaded.
